alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with base ops, iterative shifts and optional shift-add MUL
// Optional feature macro: ALU_SEQ_MUL_EN (command 11 builds the MUL datapath; otherwise illegal)
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       command,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             err
);

    localparam int CW = SHW + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd11;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
`ifdef ALU_SEQ_MUL_EN
        S_MUL,
`endif
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic             shift_out;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     mul_sum;

    // Upper half accumulates the multiplicand whenever the current multiplier LSB is set.
    assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, acc_q} : '0);
`endif

    // Shared adder: everything except ADD runs as a + ~b + 1.
    logic             add_sub;
    logic [WIDTH-1:0] b_x;
    logic [WIDTH:0]   add_sum;
    logic             add_ovf;

    assign add_sub = (command != OP_ADD);
    assign b_x     = add_sub ? ~operand_b : operand_b;
    assign add_sum = {1'b0, operand_a} + {1'b0, b_x} + {{WIDTH{1'b0}}, add_sub};
    assign add_ovf = (operand_a[WIDTH-1] ^ b_x[WIDTH-1] ^ add_sum[WIDTH-1]) ^ add_sum[WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    case (command)
                        OP_SLL, OP_SRL, OP_SRA:
                            state_d = (operand_b[SHW-1:0] == '0) ? S_DONE : S_SHIFT;
`ifdef ALU_SEQ_MUL_EN
                        OP_MUL:  state_d = S_MUL;
`endif
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_SHIFT: if (cnt_q == CNT_ONE) state_d = S_DONE;
`ifdef ALU_SEQ_MUL_EN
            S_MUL:   if (cnt_q == CNT_ONE) state_d = S_DONE;
`endif
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        result_d  = result_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        err_d     = err_q;
        shift_out = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        prod_d    = prod_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    cmd_d    = command;
                    acc_d    = operand_a;
                    cnt_d    = {1'b0, operand_b[SHW-1:0]};
                    result_d = '0;
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                    case (command)
                        OP_ADD, OP_SUB: begin
                            result_d = add_sum[WIDTH-1:0];
                            carry_d  = add_sum[WIDTH];
                            ovf_d    = add_ovf;
                        end
                        OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, add_sum[WIDTH-1] ^ add_ovf};
                        OP_XOR:  result_d = operand_a ^ operand_b;
                        OP_AND:  result_d = operand_a & operand_b;
                        OP_NAND: result_d = ~(operand_a & operand_b);
                        OP_NOR:  result_d = ~(operand_a | operand_b);
                        OP_OR:   result_d = operand_a | operand_b;
                        OP_SLL, OP_SRL, OP_SRA: result_d = operand_a;
`ifdef ALU_SEQ_MUL_EN
                        OP_MUL: begin
                            prod_d = {{WIDTH{1'b0}}, operand_b};
                            cnt_d  = CW'(WIDTH);
                        end
`endif
                        default: err_d = 1'b1;
                    endcase
                    zero_d = (result_d == '0);
                end
            end
            S_SHIFT: begin
                case (cmd_q)
                    OP_SLL: begin
                        acc_d     = {acc_q[WIDTH-2:0], 1'b0};
                        shift_out = acc_q[WIDTH-1];
                    end
                    OP_SRL: begin
                        acc_d     = {1'b0, acc_q[WIDTH-1:1]};
                        shift_out = acc_q[0];
                    end
                    default: begin
                        acc_d     = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
                        shift_out = acc_q[0];
                    end
                endcase
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    result_d = acc_d;
                    carry_d  = shift_out;
                    zero_d   = (acc_d == '0);
                end
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
                prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    result_d = prod_d[WIDTH-1:0];
                    ovf_d    = |prod_d[2*WIDTH-1:WIDTH];
                    zero_d   = (prod_d[WIDTH-1:0] == '0);
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            cmd_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            prod_q   <= '0;
`endif
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
`ifdef ALU_SEQ_MUL_EN
            prod_q   <= prod_d;
`endif
        end
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        result    = result_q;
        carryout  = carry_q;
        overflow  = ovf_q;
        zero      = zero_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed table plus randomized reference-model checks for alu_seq
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  command;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carryout;
    logic        overflow;
    logic        zero;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .command   (command),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carryout  (carryout),
        .overflow  (overflow),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;  // {carryout, overflow, zero, err}
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour from the arithmetic definitions, independent of datapath structure.
    task automatic model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [3:0] fl, output int lat);
        logic [32:0]        s;
        logic [63:0]        p;
        logic signed [31:0] sa;
        logic               cy, ov, er;
        int                 sh;
        sh  = int'(b[4:0]);
        sa  = a;
        r   = 32'h0;
        cy  = 1'b0;
        ov  = 1'b0;
        er  = 1'b0;
        lat = 1;
        case (cmd)
            4'd0: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0];
                cy = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd1: begin
                s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r  = s[31:0];
                cy = s[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd2: r = a ^ b;
            4'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4: r = a & b;
            4'd5: r = ~(a & b);
            4'd6: r = ~(a | b);
            4'd7: r = a | b;
            4'd8: begin
                r = a << sh;
                if (sh > 0) cy = a[32-sh];
                lat = sh + 1;
            end
            4'd9: begin
                r = a >> sh;
                if (sh > 0) cy = a[sh-1];
                lat = sh + 1;
            end
            4'd10: begin
                r = sa >>> sh;
                if (sh > 0) cy = a[sh-1];
                lat = sh + 1;
            end
`ifdef ALU_SEQ_MUL_EN
            4'd11: begin
                p   = {32'h0, a} * {32'h0, b};
                r   = p[31:0];
                ov  = (p[63:32] != 32'h0);
                lat = 33;
            end
`endif
            default: er = 1'b1;
        endcase
        fl = {cy, ov, (r == 32'h0), er};
    endtask

    task automatic do_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input int hold, output logic [31:0] r, output logic [3:0] fl,
                         output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        command   = cmd;
        operand_a = a;
        operand_b = b;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        command   = 4'($urandom);
        operand_a = $urandom;
        operand_b = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        r  = result;
        fl = {carryout, overflow, zero, err};
        for (int h = 0; h < hold; h++) begin
            in_valid  = 1'($urandom);
            command   = 4'($urandom);
            operand_a = $urandom;
            operand_b = $urandom;
            @(negedge clk);
            chk("hold_result", result, r);
            chk("hold_flags", {carryout, overflow, zero, err}, fl);
            chk("hold_ready_valid", {in_ready, out_valid}, 2'b01);
        end
        // in_valid stays high across the handshake edge: it must not be taken there.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("release_idle", {in_ready, out_valid}, 2'b10);
    endtask

    vec_t        tbl[13];
    logic [31:0] r, er_;
    logic [3:0]  fl, efl;
    int          lat, elat;

    initial begin
        tbl[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0100, 1};
        tbl[1]  = '{4'd1,  32'd5,        32'd5,        32'h00000000, 4'b1010, 1};
        tbl[2]  = '{4'd3,  32'hFFFFFFFF, 32'd1,        32'h00000001, 4'b0000, 1};
        tbl[3]  = '{4'd3,  32'h80000000, 32'd1,        32'h00000001, 4'b0000, 1};
        tbl[4]  = '{4'd10, 32'h80000000, 32'd4,        32'hF8000000, 4'b0000, 5};
        tbl[5]  = '{4'd8,  32'h00000001, 32'd0,        32'h00000001, 4'b0000, 1};
`ifdef ALU_SEQ_MUL_EN
        tbl[6]  = '{4'd11, 32'h00010000, 32'h00010000, 32'h00000000, 4'b0110, 33};
`else
        tbl[6]  = '{4'd11, 32'h00010000, 32'h00010000, 32'h00000000, 4'b0011, 1};
`endif
        tbl[7]  = '{4'd15, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 4'b0011, 1};
        tbl[8]  = '{4'd9,  32'h0000000F, 32'd2,        32'h00000003, 4'b1000, 3};
        tbl[9]  = '{4'd5,  32'hFFFF0000, 32'hFF00FF00, 32'h00FFFFFF, 4'b0000, 1};
        tbl[10] = '{4'd1,  32'h00000000, 32'd1,        32'hFFFFFFFF, 4'b0000, 1};
        tbl[11] = '{4'd8,  32'h00000003, 32'd31,       32'h80000000, 4'b1000, 32};
        tbl[12] = '{4'd6,  32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000, 4'b0010, 1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        command   = 4'd0;
        operand_a = 32'h0;
        operand_b = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset_ready_valid", {in_ready, out_valid}, 2'b10);
        chk("reset_result", result, 32'h0);
        chk("reset_flags", {carryout, overflow, zero, err}, 4'b0000);
        reset = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) begin
            do_op(tbl[i].cmd, tbl[i].a, tbl[i].b, (i == 0) ? 3 : (i % 2), r, fl, lat);
            chk($sformatf("tbl%0d_result", i), r, tbl[i].res);
            chk($sformatf("tbl%0d_flags", i), fl, tbl[i].flags);
            chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
        end

        // Reset three cycles into a long SRL discards it immediately.
        command   = 4'd9;
        operand_a = 32'hFFFFFFFF;
        operand_b = 32'd20;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midop_reset_ready_valid", {in_ready, out_valid}, 2'b10);
        chk("midop_reset_result", result, 32'h0);
        chk("midop_reset_flags", {carryout, overflow, zero, err}, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_op(4'd0, 32'd2, 32'd3, 0, r, fl, lat);
        chk("post_reset_add", r, 32'd5);
        chk("post_reset_add_flags", fl, 4'b0000);
        chk("post_reset_add_latency", 64'(lat), 64'd1);

        for (int k = 0; k < 40; k++) begin
            logic [3:0]  c;
            logic [31:0] a, b;
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            case (k % 5)
                1: b = a;
                2: a = 32'h80000000;
                3: b = 32'($urandom_range(0, 3));
                default: ;
            endcase
            model(c, a, b, er_, efl, elat);
            do_op(c, a, b, k % 3, r, fl, lat);
            chk($sformatf("rnd%0d_cmd%0d_result", k, c), r, er_);
            chk($sformatf("rnd%0d_cmd%0d_flags", k, c), fl, efl);
            chk($sformatf("rnd%0d_cmd%0d_latency", k, c), 64'(lat), 64'(elat));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
